alu_sequencer: RTL and testbench

Sequential controller wrapping the 20-bit ALU datapath (logic, shift/rotate, arithmetic, comparison and program-flow operations). It accepts one operation at a time over a valid/ready handshake and latches the operands. It executes the operation in half-word or full-word mode and owns the CPU status register (carry, sign, zero). It returns the result over a second valid/ready handshake, and it resolves conditional jumps and trap entry for the fetch stage.

---
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the fetch/issue side (master) and the ALU sequencer (slave).
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 20
);
  logic             op_valid;
  logic             op_ready;
  logic [4:0]       op_code;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_a;
  logic [WIDTH-1:0] res_b;
  logic [2:0]       status;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             trap;

  modport master (
    output op_valid, op_code, mode, a, b, res_ready,
    input  op_ready, res_valid, res_a, res_b, status, branch_taken, branch_target, trap
  );

  modport slave (
    input  op_valid, op_code, mode, a, b, res_ready,
    output op_ready, res_valid, res_a, res_b, status, branch_taken, branch_target, trap
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequential controller around the 20-bit ALU: latches one op, executes it in half/full-word
// mode, owns the {C,S,Z} status register and resolves jumps/trap for the fetch stage.
module alu_sequencer #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned HALF  = 10
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE, S_TRAP} state_e;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_TRAP = 5'd1,  OP_NOT = 5'd2,  OP_AND = 5'd3,  OP_OR   = 5'd4,
    OP_XOR  = 5'd5,  OP_SHR  = 5'd6,  OP_SHL = 5'd7,  OP_ROR = 5'd8,  OP_ROL  = 5'd9,
    OP_SWP  = 5'd10, OP_INC  = 5'd11, OP_DEC = 5'd12, OP_ADD = 5'd13, OP_ADC  = 5'd14,
    OP_SUB  = 5'd15, OP_SBC  = 5'd16, OP_EQ  = 5'd17, OP_GT  = 5'd18, OP_LT   = 5'd19,
    OP_GE   = 5'd20, OP_LE   = 5'd21, OP_LDSR = 5'd22, OP_XSR = 5'd23, OP_JMP = 5'd24,
    OP_JZ   = 5'd25, OP_JS   = 5'd26, OP_JZS = 5'd27
  } op_e;

  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

  state_e           state_q, state_d;
  logic [4:0]       op_q;
  logic             mode_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       status_q;
  logic [WIDTH-1:0] res_a_q, res_b_q, target_q;
  logic             taken_q;

  logic [WIDTH-1:0] mask, a_m, b_m, opnd;
  logic             a_top, r_top, c_in, carry_in;
  logic [WIDTH:0]   sum, dif;
  logic             sum_c, dif_b;
  logic [WIDTH-1:0] r_a, r_b, r_target;
  logic             r_taken, flag_c, upd_zs, upd_cmp, is_trap;
  logic [2:0]       st_next;

  // Datapath: everything works on masked operands so half-word mode never sees upper bits.
  always_comb begin
    mask     = mode_q ? '1 : HALF_MASK;
    a_m      = a_q & mask;
    b_m      = b_q & mask;
    a_top    = mode_q ? a_q[WIDTH-1] : a_q[HALF-1];
    c_in     = status_q[2];
    opnd     = ((op_q == OP_INC) || (op_q == OP_DEC)) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_m;
    carry_in = ((op_q == OP_ADC) || (op_q == OP_SBC)) ? c_in : 1'b0;
    sum      = {1'b0, a_m} + {1'b0, opnd} + {{WIDTH{1'b0}}, carry_in};
    dif      = {1'b0, a_m} - {1'b0, opnd} - {{WIDTH{1'b0}}, carry_in};
    sum_c    = mode_q ? sum[WIDTH] : sum[HALF];
    dif_b    = mode_q ? dif[WIDTH] : dif[HALF];

    r_a      = '0;
    r_b      = '0;
    r_target = '0;
    r_taken  = 1'b0;
    flag_c   = c_in;
    upd_zs   = 1'b0;
    upd_cmp  = 1'b0;
    is_trap  = 1'b0;
    st_next  = status_q;

    case (op_q)
      OP_NOP:  ;
      OP_NOT:  begin r_a = ~a_m & mask;  upd_zs = 1'b1; end
      OP_AND:  begin r_a = a_m & b_m;    upd_zs = 1'b1; end
      OP_OR:   begin r_a = a_m | b_m;    upd_zs = 1'b1; end
      OP_XOR:  begin r_a = a_m ^ b_m;    upd_zs = 1'b1; end
      OP_SHR:  begin r_a = a_m >> 1; flag_c = a_m[0]; upd_zs = 1'b1; end
      OP_SHL:  begin r_a = (a_m << 1) & mask; flag_c = a_top; upd_zs = 1'b1; end
      OP_ROR: begin
        r_a = a_m >> 1;
        if (mode_q) r_a[WIDTH-1] = a_m[0];
        else        r_a[HALF-1]  = a_m[0];
        upd_zs = 1'b1;
      end
      OP_ROL: begin
        r_a    = (a_m << 1) & mask;
        r_a[0] = a_top;
        upd_zs = 1'b1;
      end
      OP_SWP:  begin r_a = b_m; r_b = a_m; end
      OP_INC, OP_ADD, OP_ADC: begin r_a = sum[WIDTH-1:0] & mask; flag_c = sum_c; upd_zs = 1'b1; end
      OP_DEC, OP_SUB, OP_SBC: begin r_a = dif[WIDTH-1:0] & mask; flag_c = dif_b; upd_zs = 1'b1; end
      OP_EQ:   begin r_a = {{(WIDTH-1){1'b0}}, a_m == b_m}; upd_cmp = 1'b1; end
      OP_GT:   begin r_a = {{(WIDTH-1){1'b0}}, a_m >  b_m}; upd_cmp = 1'b1; end
      OP_LT:   begin r_a = {{(WIDTH-1){1'b0}}, a_m <  b_m}; upd_cmp = 1'b1; end
      OP_GE:   begin r_a = {{(WIDTH-1){1'b0}}, a_m >= b_m}; upd_cmp = 1'b1; end
      OP_LE:   begin r_a = {{(WIDTH-1){1'b0}}, a_m <= b_m}; upd_cmp = 1'b1; end
      OP_LDSR: st_next = a_q[2:0];
      OP_XSR:  st_next = status_q ^ a_q[2:0];
      OP_JMP:  begin r_taken = 1'b1;                  r_target = a_m; end
      OP_JZ:   begin r_taken = status_q[0];           r_target = a_m; end
      OP_JS:   begin r_taken = status_q[1];           r_target = a_m; end
      OP_JZS:  begin r_taken = |status_q[1:0];        r_target = a_m; end
      default: is_trap = 1'b1;
    endcase

    r_top = mode_q ? r_a[WIDTH-1] : r_a[HALF-1];
    if (upd_zs)  st_next = {flag_c, r_top, r_a == '0};
    if (upd_cmp) st_next = {c_in, a_m < b_m, a_m == b_m};
  end

  always_comb begin
    state_d      = state_q;
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.trap      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = is_trap ? S_TRAP : S_DONE;
      S_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = S_IDLE;
      end
      S_TRAP: bus.trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      status_q <= '0;
      res_a_q  <= '0;
      res_b_q  <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.op_valid) begin
          op_q   <= bus.op_code;
          mode_q <= bus.mode;
          a_q    <= bus.a;
          b_q    <= bus.b;
        end
        S_EXEC: begin
          res_a_q  <= r_a;
          res_b_q  <= r_b;
          target_q <= r_target;
          taken_q  <= r_taken;
          status_q <= st_next;
        end
        S_DONE: if (bus.res_ready) taken_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.res_a         = res_a_q;
  assign bus.res_b         = res_b_q;
  assign bus.status        = status_q;
  assign bus.branch_taken  = taken_q;
  assign bus.branch_target = target_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [2:0] m_status = 3'b000;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(20)) bus();

  alu_sequencer #(.WIDTH(20), .HALF(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [19:0] ra;
    logic [19:0] rb;
    logic [2:0]  st;
    logic        tk;
    logic [19:0] tg;
  } exp_t;

  // Reference: integer arithmetic modulo 2^w, flags from the resulting value.
  function automatic exp_t ref_op(input int op, input logic md, input logic [19:0] a,
                                  input logic [19:0] b, input logic [2:0] st);
    exp_t   e;
    longint m, av, bv, r, cin;
    logic   c_f, s_f, z_f;
    bit     flags;
    m     = md ? 64'sd1048576 : 64'sd1024;
    av    = longint'(a) % m;
    bv    = longint'(b) % m;
    cin   = st[2] ? 64'sd1 : 64'sd0;
    c_f   = st[2]; s_f = st[1]; z_f = st[0];
    r     = 0;
    flags = 0;
    e     = '0;
    case (op)
      2:  begin r = m - 1 - av; flags = 1; end
      3:  begin r = av & bv; flags = 1; end
      4:  begin r = av | bv; flags = 1; end
      5:  begin r = av ^ bv; flags = 1; end
      6:  begin r = av / 2; c_f = (av % 2) == 1; flags = 1; end
      7:  begin r = (av * 2) % m; c_f = av >= m / 2; flags = 1; end
      8:  begin r = av / 2 + (av % 2) * (m / 2); flags = 1; end
      9:  begin r = (av * 2) % m + av / (m / 2); flags = 1; end
      11: begin r = av + 1;         c_f = r >= m; r = r % m; flags = 1; end
      12: begin r = av - 1;         c_f = r < 0;  r = (r + m) % m; flags = 1; end
      13: begin r = av + bv;        c_f = r >= m; r = r % m; flags = 1; end
      14: begin r = av + bv + cin;  c_f = r >= m; r = r % m; flags = 1; end
      15: begin r = av - bv;        c_f = r < 0;  r = (r + m) % m; flags = 1; end
      16: begin r = av - bv - cin;  c_f = r < 0;  r = (r + m) % m; flags = 1; end
      17: r = (av == bv) ? 1 : 0;
      18: r = (av >  bv) ? 1 : 0;
      19: r = (av <  bv) ? 1 : 0;
      20: r = (av >= bv) ? 1 : 0;
      21: r = (av <= bv) ? 1 : 0;
      24: e.tk = 1'b1;
      25: e.tk = st[0];
      26: e.tk = st[1];
      27: e.tk = st[0] | st[1];
      default: ;
    endcase
    if (op >= 17 && op <= 21) begin z_f = av == bv; s_f = av < bv; end
    if (flags) begin z_f = (r == 0); s_f = (r >= m / 2); end
    e.ra = 20'(r);
    e.st = {c_f, s_f, z_f};
    if (op == 10) begin e.ra = 20'(bv); e.rb = 20'(av); end
    if (op == 22) e.st = a[2:0];
    if (op == 23) e.st = st ^ a[2:0];
    if (op >= 24 && op <= 27) e.tg = 20'(av);
    return e;
  endfunction

  // Issue one op; lat = edges from acceptance until res_valid/trap seen, -1 on timeout.
  task automatic issue(input logic [4:0] op, input logic md, input logic [19:0] av,
                       input logic [19:0] bv, output int lat);
    int n;
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.mode     = md;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.a        = 20'($urandom);
    bus.b        = 20'($urandom);
    lat = 0;
    while (bus.res_valid !== 1'b1 && bus.trap !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.res_valid !== 1'b1 && bus.trap !== 1'b1) lat = -1;
  endtask

  task automatic take();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    bus.op_code = '0; bus.mode = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_status = 3'b000;
    checks++;
    if ({bus.op_ready, bus.res_valid, bus.trap, bus.branch_taken} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got rdy/vld/trap/tk=%b exp=1000",
               {bus.op_ready, bus.res_valid, bus.trap, bus.branch_taken});
    end
    checks++;
    if (bus.status !== 3'b000) begin
      failures++; $display("FAIL reset_status got=%b exp=000", bus.status);
    end
    checks++;
    if ({bus.res_a, bus.res_b, bus.branch_target} !== 60'h0) begin
      failures++;
      $display("FAIL reset_data got res_a=%h res_b=%h tgt=%h exp=0", bus.res_a, bus.res_b, bus.branch_target);
    end
  endtask

  task automatic test_add_full();
    int lat;
    issue(5'd13, 1'b1, 20'hFFFFF, 20'h00001, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_full_latency got=%0d exp=1", lat); end
    checks++;
    if (bus.res_a !== 20'h00000 || bus.status !== 3'b101 || bus.op_ready !== 1'b0) begin
      failures++;
      $display("FAIL add_full got res_a=%h st=%b rdy=%b exp res_a=00000 st=101 rdy=0",
               bus.res_a, bus.status, bus.op_ready);
    end
    m_status = 3'b101;
    take();
  endtask

  task automatic test_add_half_adc();
    int lat;
    issue(5'd13, 1'b0, 20'hFFBFF, 20'h00001, lat);
    checks++;
    if (lat !== 1 || bus.res_a !== 20'h00000 || bus.status !== 3'b101) begin
      failures++;
      $display("FAIL add_half got lat=%0d res_a=%h st=%b exp lat=1 res_a=00000 st=101", lat, bus.res_a, bus.status);
    end
    take();
    issue(5'd14, 1'b0, 20'h00000, 20'h00000, lat);
    checks++;
    if (lat !== 1 || bus.res_a !== 20'h00001 || bus.status !== 3'b000) begin
      failures++;
      $display("FAIL adc_carry_in got lat=%0d res_a=%h st=%b exp lat=1 res_a=00001 st=000", lat, bus.res_a, bus.status);
    end
    m_status = 3'b000;
    take();
  endtask

  task automatic test_shl_swp();
    int lat;
    issue(5'd7, 1'b1, 20'h80001, 20'h00000, lat);
    checks++;
    if (bus.res_a !== 20'h00002 || bus.status !== 3'b100) begin
      failures++; $display("FAIL shl got res_a=%h st=%b exp res_a=00002 st=100", bus.res_a, bus.status);
    end
    take();
    issue(5'd10, 1'b1, 20'h12345, 20'h0ABCD, lat);
    checks++;
    if (bus.res_a !== 20'h0ABCD || bus.res_b !== 20'h12345 || bus.status !== 3'b100) begin
      failures++;
      $display("FAIL swp got res_a=%h res_b=%h st=%b exp 0abcd 12345 100", bus.res_a, bus.res_b, bus.status);
    end
    m_status = 3'b100;
    take();
  endtask

  task automatic test_cmp_branch();
    int lat;
    issue(5'd19, 1'b1, 20'd5, 20'd9, lat);
    checks++;
    if (bus.res_a !== 20'h00001 || bus.status !== 3'b110) begin
      failures++; $display("FAIL lt got res_a=%h st=%b exp res_a=00001 st=110", bus.res_a, bus.status);
    end
    take();
    issue(5'd26, 1'b1, 20'h00123, 20'h00000, lat);
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.branch_target !== 20'h00123 || bus.res_a !== 20'h0 || bus.status !== 3'b110) begin
      failures++;
      $display("FAIL js got tk=%b tgt=%h res_a=%h st=%b exp tk=1 tgt=00123 res_a=0 st=110",
               bus.branch_taken, bus.branch_target, bus.res_a, bus.status);
    end
    take();
    checks++;
    if (bus.branch_taken !== 1'b0) begin
      failures++; $display("FAIL branch_clear got tk=%b exp=0", bus.branch_taken);
    end
    issue(5'd25, 1'b1, 20'h00456, 20'h00000, lat);
    checks++;
    if (bus.branch_taken !== 1'b0 || bus.branch_target !== 20'h00456) begin
      failures++; $display("FAIL jz got tk=%b tgt=%h exp tk=0 tgt=00456", bus.branch_taken, bus.branch_target);
    end
    m_status = 3'b110;
    take();
  endtask

  task automatic test_backpressure();
    int lat;
    bit bad;
    exp_t e, e2;
    logic [19:0] a0, b0, a1, b1;
    a0 = 20'($urandom); b0 = 20'($urandom);
    a1 = 20'($urandom); b1 = 20'($urandom);
    e = ref_op(5, 1'b1, a0, b0, m_status);
    issue(5'd5, 1'b1, a0, b0, lat);
    checks++;
    if (lat !== 1 || bus.res_a !== e.ra || bus.status !== e.st) begin
      failures++;
      $display("FAIL xor got lat=%0d res_a=%h st=%b exp lat=1 res_a=%h st=%b", lat, bus.res_a, bus.status, e.ra, e.st);
    end
    bus.op_valid = 1'b1; bus.op_code = 5'd13; bus.mode = 1'b0; bus.a = a1; bus.b = b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b1 || bus.res_a !== e.ra || bus.status !== e.st || bus.op_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL backpressure_hold got vld=%b res_a=%h st=%b rdy=%b exp vld=1 res_a=%h st=%b rdy=0",
               bus.res_valid, bus.res_a, bus.status, bus.op_ready, e.ra, e.st);
    end
    m_status = e.st;
    e2 = ref_op(13, 1'b0, a1, b1, m_status);
    take();
    checks++;
    if (bus.op_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL handshake_idle got rdy=%b vld=%b exp rdy=1 vld=0", bus.op_ready, bus.res_valid);
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    checks++;
    if (bus.op_ready !== 1'b0) begin
      failures++; $display("FAIL second_accept got rdy=%b exp=0", bus.op_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_a !== e2.ra || bus.status !== e2.st) begin
      failures++;
      $display("FAIL second_op got vld=%b res_a=%h st=%b exp vld=1 res_a=%h st=%b",
               bus.res_valid, bus.res_a, bus.status, e2.ra, e2.st);
    end
    m_status = e2.st;
    take();
  endtask

  task automatic test_trap();
    int lat;
    bit bad;
    issue(5'd22, 1'b1, 20'h00007, 20'h0, lat);
    checks++;
    if (bus.status !== 3'b111 || bus.res_a !== 20'h0) begin
      failures++; $display("FAIL ldsr got st=%b res_a=%h exp st=111 res_a=0", bus.status, bus.res_a);
    end
    take();
    issue(5'd31, 1'b1, 20'($urandom), 20'($urandom), lat);
    checks++;
    if (lat !== 1 || bus.trap !== 1'b1 || bus.op_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL trap_entry got lat=%0d trap=%b rdy=%b vld=%b exp lat=1 trap=1 rdy=0 vld=0",
               lat, bus.trap, bus.op_ready, bus.res_valid);
    end
    bus.op_valid = 1'b1; bus.op_code = 5'd13; bus.res_ready = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.trap !== 1'b1 || bus.op_ready !== 1'b0 || bus.res_valid !== 1'b0) bad = 1;
    end
    bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    checks++;
    if (bad) begin
      failures++; $display("FAIL trap_sticky got trap=%b rdy=%b exp trap=1 rdy=0", bus.trap, bus.op_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_status = 3'b000;
    checks++;
    if (bus.op_ready !== 1'b1 || bus.trap !== 1'b0 || bus.status !== 3'b000) begin
      failures++;
      $display("FAIL trap_reset got rdy=%b trap=%b st=%b exp rdy=1 trap=0 st=000", bus.op_ready, bus.trap, bus.status);
    end
  endtask

  task automatic test_reset_in_exec();
    int lat;
    bit bad;
    issue(5'd22, 1'b1, 20'h00005, 20'h0, lat);
    take();
    bus.op_valid = 1'b1; bus.op_code = 5'd13; bus.mode = 1'b1;
    bus.a = 20'h00010; bus.b = 20'h00020;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    checks++;
    if (bus.op_ready !== 1'b0) begin
      failures++; $display("FAIL exec_accept got rdy=%b exp=0", bus.op_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_status = 3'b000;
    bad = 0;
    repeat (4) begin
      if (bus.res_valid !== 1'b0 || bus.op_ready !== 1'b1 || bus.status !== 3'b000 || bus.res_a !== 20'h0) bad = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_in_exec got vld=%b rdy=%b st=%b res_a=%h exp vld=0 rdy=1 st=000 res_a=0",
               bus.res_valid, bus.op_ready, bus.status, bus.res_a);
    end
  endtask

  task automatic test_random();
    int lat, op;
    logic md;
    logic [19:0] av, bv;
    exp_t e;
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 26));
      if (op >= 1) op++;
      md = 1'($urandom_range(0, 1));
      av = 20'($urandom);
      bv = 20'($urandom);
      if ($urandom_range(0, 5) == 0) bv = av;
      e = ref_op(op, md, av, bv, m_status);
      issue(5'(op), md, av, bv, lat);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      checks++;
      if (lat !== 1 || bus.res_valid !== 1'b1 || bus.res_a !== e.ra || bus.res_b !== e.rb ||
          bus.status !== e.st || bus.branch_taken !== e.tk || bus.branch_target !== e.tg) begin
        failures++;
        $display("FAIL random op=%0d mode=%b a=%h b=%h got lat=%0d res_a=%h res_b=%h st=%b tk=%b tgt=%h exp res_a=%h res_b=%h st=%b tk=%b tgt=%h",
                 op, md, av, bv, lat, bus.res_a, bus.res_b, bus.status, bus.branch_taken, bus.branch_target,
                 e.ra, e.rb, e.st, e.tk, e.tg);
      end
      m_status = e.st;
      take();
    end
  endtask

  initial begin
    test_reset();
    test_add_full();
    test_add_half_adc();
    test_shl_swp();
    test_cmp_branch();
    test_backpressure();
    test_trap();
    test_reset_in_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
